// File: rtl/ppu_pixel_fifo.sv
// ppu_pixel_fifo: show-ahead elastic buffer between the PPU pixel pipeline
// and VGA scan-out. Each entry is a 6-bit NES palette index tagged with a
// start-of-frame bit. A three-state FSM holds the reader off until a frame
// boundary arrives. After an overflow it restarts the queue on the next
// start-of-frame word.
module ppu_pixel_fifo #(
   parameter int DATA_W = 6,
   parameter int DEPTH  = 512,
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_idx,
   input  logic              wr_sof,
   output logic              full,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_idx,
   output logic              rd_sof,
   output logic              empty,
   output logic [ADDR_W:0]   level,
   output logic              overflow,
   output logic              underflow,
   input  logic              clr_err,
   output logic              frame_sync
);

   typedef struct packed {
      logic              sof;
      logic [DATA_W-1:0] idx;
   } pix_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      RESYNC = 2'd2
   } state_t;

   // Palette index shown to the VGA side whenever nothing valid is presentable.
   localparam logic [DATA_W-1:0] BLANK_IDX = DATA_W'(6'h0F);
   localparam logic [ADDR_W:0]   FULL_LVL  = (ADDR_W+1)'(DEPTH);

   state_t            state;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   level_q;
   pix_t              mem [DEPTH];
   pix_t              head;
   pix_t              wr_word;

   logic in_run;
   logic restart;
   logic push;
   logic pop;
   logic drop;
   logic rd_err;
   logic show;

   assign level   = level_q;
   assign empty   = (level_q == '0);
   assign full    = (level_q == FULL_LVL);
   assign wr_word = {wr_sof, wr_idx};
   assign head    = mem[rd_ptr];

   // Event decode. Outside RUN, only a start-of-frame write does anything.
   // That write restarts the queue at address 0. Inside RUN, a write into a
   // full queue is accepted only if a pop frees a slot on the same edge.
   always_comb begin
      in_run  = (state == RUN);
      restart = (state != RUN) && wr_en && wr_sof;
      pop     = in_run && rd_en && !empty;
      push    = in_run && wr_en && (!full || rd_en);
      drop    = in_run && wr_en && full && !rd_en;
      rd_err  = in_run && rd_en && empty;
      show    = in_run && !empty;
   end

   // Show-ahead head: present the head word only while RUN has data.
   always_comb begin
      rd_idx = BLANK_IDX;
      rd_sof = 1'b0;
      if (show) begin
         rd_idx = head.idx;
         rd_sof = head.sof;
      end
   end

   // Storage array. It has no reset, so stale words are simply overwritten later.
   always_ff @(posedge clk) begin
      if (restart)
         mem[0] <= wr_word;
      else if (push)
         mem[wr_ptr] <= wr_word;
   end

   // Pointer and occupancy bookkeeping. A restart puts the SOF word at slot 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else if (restart) begin
         wr_ptr  <= ADDR_W'(1);
         rd_ptr  <= '0;
         level_q <= (ADDR_W+1)'(1);
      end else begin
         if (push)
            wr_ptr <= wr_ptr + ADDR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + ADDR_W'(1);
         case ({push, pop})
            2'b10:   level_q <= level_q + (ADDR_W+1)'(1);
            2'b01:   level_q <= level_q - (ADDR_W+1)'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // Frame alignment FSM: wait for SOF, run, and fall back to RESYNC on overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (restart) state <= RUN;
            RUN:     if (drop)    state <= RESYNC;
            RESYNC:  if (restart) state <= RUN;
            default: state <= IDLE;
         endcase
      end
   end

   // Sticky error flags. A set event wins over a clear on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= (overflow  && !clr_err) || drop;
         underflow <= (underflow && !clr_err) || rd_err;
      end
   end

   // Pulse one cycle after a start-of-frame word leaves the queue.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         frame_sync <= 1'b0;
      else
         frame_sync <= pop && head.sof;
   end

endmodule

// File: tb/tb_ppu_pixel_fifo.sv
// Self-checking bench for ppu_pixel_fifo. The reference model is a queue of
// {sof, idx} words plus a mode variable. Every output is checked after every
// clock edge.
module tb_ppu_pixel_fifo;

   localparam int DATA_W = 6;
   localparam int DEPTH  = 512;
   localparam int ADDR_W = 9;

   logic              clk = 1'b0;
   logic              reset;
   logic              wr_en;
   logic [DATA_W-1:0] wr_idx;
   logic              wr_sof;
   logic              full;
   logic              rd_en;
   logic [DATA_W-1:0] rd_idx;
   logic              rd_sof;
   logic              empty;
   logic [ADDR_W:0]   level;
   logic              overflow;
   logic              underflow;
   logic              clr_err;
   logic              frame_sync;

   ppu_pixel_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_sof(wr_sof), .full(full),
      .rd_en(rd_en), .rd_idx(rd_idx), .rd_sof(rd_sof), .empty(empty),
      .level(level), .overflow(overflow), .underflow(underflow),
      .clr_err(clr_err), .frame_sync(frame_sync)
   );

   always #5 clk = ~clk;

   typedef enum {M_IDLE, M_RUN, M_RESYNC} mode_t;

   mode_t            m_mode;
   logic [DATA_W:0]  m_q[$];
   bit               m_ovf, m_unf, m_fs;
   int               n_chk = 0;
   int               n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE;
      m_q.delete();
      m_ovf = 0;
      m_unf = 0;
      m_fs  = 0;
   endtask

   // Advance the reference model by one clock edge with the given inputs.
   task automatic model_step(input bit we, input logic [DATA_W-1:0] idx, input bit sof,
                             input bit re, input bit clr);
      logic [DATA_W:0] w;
      bit ovf_set, unf_set, fs;
      int sz;
      w = {sof, idx};
      ovf_set = 0;
      unf_set = 0;
      fs = 0;
      sz = m_q.size();
      if (m_mode == M_RUN) begin
         if (re) begin
            if (sz > 0) begin
               fs = m_q[0][DATA_W];
               void'(m_q.pop_front());
            end else begin
               unf_set = 1;
            end
         end
         if (we) begin
            if (sz < DEPTH || re) m_q.push_back(w);
            else begin
               ovf_set = 1;
               m_mode  = M_RESYNC;
            end
         end
      end else if (we && sof) begin
         m_q.delete();
         m_q.push_back(w);
         m_mode = M_RUN;
      end
      m_ovf = (m_ovf && !clr) || ovf_set;
      m_unf = (m_unf && !clr) || unf_set;
      m_fs  = fs;
   endtask

   task automatic check_all(input string tag);
      bit show;
      int exp_idx, exp_sof;
      show    = (m_mode == M_RUN) && (m_q.size() > 0);
      exp_idx = show ? int'(m_q[0][DATA_W-1:0]) : 'h0F;
      exp_sof = show ? int'(m_q[0][DATA_W]) : 0;
      chk({tag, ".level"},      32'(level),      32'(m_q.size()));
      chk({tag, ".empty"},      32'(empty),      32'(m_q.size() == 0));
      chk({tag, ".full"},       32'(full),       32'(m_q.size() == DEPTH));
      chk({tag, ".rd_idx"},     32'(rd_idx),     32'(exp_idx));
      chk({tag, ".rd_sof"},     32'(rd_sof),     32'(exp_sof));
      chk({tag, ".overflow"},   32'(overflow),   32'(m_ovf));
      chk({tag, ".underflow"},  32'(underflow),  32'(m_unf));
      chk({tag, ".frame_sync"}, 32'(frame_sync), 32'(m_fs));
   endtask

   // Drive one cycle of inputs, clock it, then compare DUT against the model.
   task automatic step(input string tag, input bit we, input logic [DATA_W-1:0] idx,
                       input bit sof, input bit re, input bit clr);
      wr_en   = we;
      wr_idx  = idx;
      wr_sof  = sof;
      rd_en   = re;
      clr_err = clr;
      model_step(we, idx, sof, re, clr);
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      int ph_wr, ph_rd;
      reset = 1'b1;
      wr_en = 0; wr_idx = '0; wr_sof = 0; rd_en = 0; clr_err = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      reset = 1'b0;

      // 1: non-SOF writes are ignored in IDLE; a SOF write starts RUN.
      step("t1_drop0", 1, 6'h05, 0, 0, 0);
      step("t1_drop1", 1, 6'h06, 0, 1, 0);
      step("t1_drop2", 1, 6'h07, 0, 0, 0);
      step("t1_sof",   1, 6'h21, 1, 0, 0);
      chk("t1_head", 32'(rd_idx), 32'h21);

      // 2: fill to full, overflow into RESYNC, then restart on a SOF write.
      step("t2_pop", 0, '0, 0, 1, 0);
      for (int i = 0; i < DEPTH; i++)
         step("t2_fill", 1, 6'(i), (i == 0), 0, 0);
      chk("t2_full", 32'(full), 32'd1);
      step("t2_ovf",    1, 6'h3F, 0, 0, 0);
      step("t2_rs_rd",  0, '0,    0, 1, 0);
      step("t2_rs_non", 1, 6'h11, 0, 0, 0);
      step("t2_rs_sof", 1, 6'h30, 1, 0, 0);
      chk("t2_head", 32'(rd_idx), 32'h30);

      // 3: clear the flags, fill across the wrap, then write and read together at full.
      step("t3_clr", 0, '0, 0, 0, 1);
      for (int i = 0; i < DEPTH - 1; i++)
         step("t3_fill", 1, 6'($urandom), 0, 0, 0);
      for (int i = 0; i < 10; i++)
         step("t3_wr_rd", 1, 6'($urandom), 0, 1, 0);
      chk("t3_level", 32'(level), 32'(DEPTH));

      // 4: drain, read while empty, then clear, then clear colliding with a set.
      while (m_q.size() > 0)
         step("t4_drain", 0, '0, 0, 1, 0);
      step("t4_unf",     0, '0, 0, 1, 0);
      step("t4_clr",     0, '0, 0, 0, 1);
      step("t4_clr_set", 0, '0, 0, 1, 1);
      step("t4_wr_rd_e", 1, 6'h12, 0, 1, 0);
      step("t4_pop",     0, '0, 0, 1, 0);

      // 5: frame_sync follows a popped SOF word.
      step("t5_w0",  1, 6'h2A, 1, 0, 0);
      step("t5_w1",  1, 6'h2B, 0, 0, 0);
      step("t5_p0",  0, '0, 0, 1, 0);
      chk("t5_fs_idx", 32'(rd_idx), 32'h2B);
      step("t5_p1",  0, '0, 0, 1, 0);
      step("t5_idle", 0, '0, 0, 0, 0);

      // 6: reset applied between edges clears everything immediately.
      for (int i = 0; i < 100; i++)
         step("t6_fill", 1, 6'($urandom), 0, 0, 0);
      step("t6_unf_prep", 0, '0, 0, 0, 0);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all("t6_async");
      @(negedge clk);
      reset = 1'b0;
      step("t6_idle_drop", 1, 6'h09, 0, 0, 0);
      step("t6_idle_rd",   0, '0, 0, 1, 0);

      // Random traffic, with write/read bias varied per phase to reach full and empty.
      for (int ph = 0; ph < 20; ph++) begin
         ph_wr = $urandom_range(10, 95);
         ph_rd = $urandom_range(10, 95);
         for (int c = 0; c < 200; c++)
            step("rand",
                 ($urandom_range(99) < ph_wr),
                 6'($urandom),
                 ($urandom_range(63) == 0),
                 ($urandom_range(99) < ph_rd),
                 ($urandom_range(49) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ppu_pixel_fifo.md
Name: ppu_pixel_fifo

Overview:
Elastic buffer between the PPU pixel pipeline (writer) and the VGA scan-out stage (reader). It stores 6-bit NES palette indices tagged with a start-of-frame bit and presents them show-ahead to the VGA controller. The VGA controller drives rd_en from its active-window read strobe and consumes rd_idx combinationally. A small FSM keeps the reader aligned to frame boundaries and recovers from overflow.

Parameters:
DATA_W, 6, palette index width
DEPTH, 512, entries (two 256-pixel lines); must be a power of two
ADDR_W, 9, log2(DEPTH)

Ports:
clk  in  1  system clock (VGA pixel clock domain; writer is in the same domain)
reset  in  1  asynchronous, active-high
wr_en  in  1  write strobe from PPU
wr_idx  in  DATA_W  palette index to store
wr_sof  in  1  marks wr_idx as first pixel of a frame
full  out  1  level == DEPTH
rd_en  in  1  pop strobe from VGA controller read enable
rd_idx  out  DATA_W  head-of-queue index; 6'h0F when no data is presentable
rd_sof  out  1  SOF tag of head word; 0 when empty
empty  out  1  level == 0
level  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write dropped while full
underflow  out  1  sticky: rd_en while empty in RUN
clr_err  in  1  synchronous clear of both sticky flags
frame_sync  out  1  one-cycle pulse, registered, one cycle after the SOF word is popped

Behaviour:
- Interface: reset is asynchronous and active-high; clock is clk. All state updates occur on posedge clk.
- Reset values: wr_ptr=0, rd_ptr=0, level=0, empty=1, full=0, rd_idx=6'h0F, rd_sof=0, overflow=0, underflow=0, frame_sync=0, FSM=IDLE. Reset mid-operation discards all contents immediately.
- Storage: DEPTH x (DATA_W+1) words, each {sof, idx}. The head word is visible combinationally with zero read latency (show-ahead). Pointers wrap modulo DEPTH.
- FSM states: IDLE, RUN, RESYNC.
- IDLE:
  - Writes with wr_sof=0 are dropped.
  - A write with wr_sof=1 is stored and the FSM moves to RUN.
  - rd_en has no effect; rd_idx=6'h0F.
- RUN:
  - Write accepted if not full, or if full with rd_en asserted in the same cycle.
  - Pop occurs if rd_en and not empty.
  - Simultaneous write and pop leaves level unchanged.
  - Write while full without rd_en: word dropped, overflow set, FSM moves to RESYNC.
  - rd_en while empty: no pop, underflow set, rd_idx=6'h0F, FSM stays in RUN.
  - Empty with simultaneous wr_en and rd_en: write accepted, underflow set, the new word is not popped.
- RESYNC:
  - Reads do not pop; rd_idx=6'h0F and rd_sof=0.
  - Writes with wr_sof=0 are dropped.
  - A write with wr_sof=1 resets both pointers and level to 0, stores the word at address 0 (level becomes 1), and the FSM moves to RUN, all in the same edge.
- frame_sync: asserted for exactly one cycle, in the cycle after a pop whose word has sof=1.
- Sticky flags: set by their events and cleared by clr_err. If clr_err coincides with a set event, the flag is set.
- level is derived from registered pointers plus a wrap bit or counter; full and empty are decoded from level.
- rd_idx and rd_sof are forced to 6'h0F and 0 whenever empty=1 or FSM != RUN.

Test Plan:
1. After reset, write 0x05, 0x06, 0x07 with wr_sof=0 -> level stays 0. Write 0x21 with wr_sof=1 -> level=1, rd_idx=0x21, rd_sof=1, empty=0.
2. From RUN, write a SOF word plus 511 more (512 total) -> full=1, level=512. Write once more without rd_en -> overflow=1, FSM RESYNC, rd_idx=0x0F. Write 0x11 with wr_sof=0 -> still RESYNC. Write 0x30 with wr_sof=1 -> level=1, rd_idx=0x30.
3. At full, assert wr_en and rd_en together for 10 cycles -> level stays 512, overflow stays 0, and the popped data follows write order across pointer wrap.
4. In RUN with empty=1, pulse rd_en -> rd_idx=0x0F, underflow=1, level=0. Assert clr_err next cycle -> underflow=0. Assert clr_err together with another empty read -> underflow stays 1.
5. Queue {sof=1,0x2A},{0,0x2B} and pop both -> frame_sync high only in the cycle after the 0x2A pop; rd_idx shows 0x2B during that cycle.
6. At level 100, assert reset between clock edges -> level=0, empty=1, rd_idx=0x0F, and flags clear without waiting for clk. After deassertion, FSM is IDLE and non-SOF writes are dropped.
